// File: rtl/rv_pkg.sv
// Shared RV32I encoding constants: in_type selector enum, base opcodes and the
// queued word layout used by the instruction encoder.
package rv_pkg;

   typedef enum logic [3:0] {
      IT_R      = 4'd0,
      IT_I      = 4'd1,
      IT_LOAD   = 4'd2,
      IT_STORE  = 4'd3,
      IT_BRANCH = 4'd4,
      IT_JAL    = 4'd5,
      IT_JALR   = 4'd6,
      IT_LUI    = 4'd7,
      IT_AUIPC  = 4'd8
   } in_type_e;

   localparam logic [6:0] OP_R      = 7'h33;
   localparam logic [6:0] OP_I      = 7'h13;
   localparam logic [6:0] OP_LOAD   = 7'h03;
   localparam logic [6:0] OP_STORE  = 7'h23;
   localparam logic [6:0] OP_BRANCH = 7'h63;
   localparam logic [6:0] OP_JAL    = 7'h6F;
   localparam logic [6:0] OP_JALR   = 7'h67;
   localparam logic [6:0] OP_LUI    = 7'h37;
   localparam logic [6:0] OP_AUIPC  = 7'h17;

   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   typedef struct packed {
      logic        illegal;
      logic [31:0] inst;
   } enc_word_t;

   // True when v is representable as a signed value whose sign bit is v[msb].
   function automatic logic sign_fits(input logic [31:0] v, input logic [4:0] msb);
      logic [31:0] s;
      s = 32'($signed(v) >>> msb);
      return (s == 32'h0000_0000) || (s == 32'hFFFF_FFFF);
   endfunction

endpackage

// File: rtl/inst_pack.sv
// Combinational RV32I field packer: builds the instruction word for one bundle
// and flags immediates that are misaligned or do not fit their field.
module inst_pack
   import rv_pkg::*;
(
   input  logic [3:0]  in_type_i,
   input  logic [4:0]  rd_i,
   input  logic [4:0]  rs1_i,
   input  logic [4:0]  rs2_i,
   input  logic [2:0]  funct3_i,
   input  logic [6:0]  funct7_i,
   input  logic [31:0] imm_i,
   output logic [31:0] word_o,
   output logic        illegal_o
);

   // Format-specific field placement; unknown selectors collapse to a flagged NOP.
   always_comb begin
      word_o    = NOP_INST;
      illegal_o = 1'b0;
      case (in_type_i)
         IT_R: word_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, OP_R};
         IT_I: begin
            word_o    = {imm_i[11:0], rs1_i, funct3_i, rd_i, OP_I};
            illegal_o = !sign_fits(imm_i, 5'd11);
         end
         IT_LOAD: begin
            word_o    = {imm_i[11:0], rs1_i, funct3_i, rd_i, OP_LOAD};
            illegal_o = !sign_fits(imm_i, 5'd11);
         end
         IT_JALR: begin
            word_o    = {imm_i[11:0], rs1_i, 3'b000, rd_i, OP_JALR};
            illegal_o = !sign_fits(imm_i, 5'd11);
         end
         IT_STORE: begin
            word_o    = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], OP_STORE};
            illegal_o = !sign_fits(imm_i, 5'd11);
         end
         IT_BRANCH: begin
            word_o    = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                         imm_i[4:1], imm_i[11], OP_BRANCH};
            illegal_o = imm_i[0] | !sign_fits(imm_i, 5'd12);
         end
         IT_JAL: begin
            word_o    = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, OP_JAL};
            illegal_o = imm_i[0] | !sign_fits(imm_i, 5'd20);
         end
         IT_LUI:   word_o = {imm_i[31:12], rd_i, OP_LUI};
         IT_AUIPC: word_o = {imm_i[31:12], rd_i, OP_AUIPC};
         default: begin
            word_o    = NOP_INST;
            illegal_o = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/inst_encoder.sv
// RV32I instruction encoder: packs field bundles into words, queues them in a
// 2-entry in-order FIFO and counts legal words delivered downstream.
module inst_encoder
   import rv_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_type,
   input  logic [4:0]       rd,
   input  logic [4:0]       rs1,
   input  logic [4:0]       rs2,
   input  logic [2:0]       funct3,
   input  logic [6:0]       funct7,
   input  logic [31:0]      imm,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_inst,
   output logic             out_illegal,
   output logic [CNT_W-1:0] enc_count
);

   logic [1:0]       count_q, count_d;
   enc_word_t        head_q, head_d;
   enc_word_t        tail_q, tail_d;
   logic [CNT_W-1:0] enc_count_q, enc_count_d;
   enc_word_t        packed_s;
   logic             push_s, pop_s;

   inst_pack u_pack (
      .in_type_i (in_type),
      .rd_i      (rd),
      .rs1_i     (rs1),
      .rs2_i     (rs2),
      .funct3_i  (funct3),
      .funct7_i  (funct7),
      .imm_i     (imm),
      .word_o    (packed_s.inst),
      .illegal_o (packed_s.illegal)
   );

   // in_ready is decoded from occupancy only, never from out_ready.
   assign in_ready    = (count_q != 2'd2);
   assign out_valid   = (count_q != 2'd0);
   assign out_inst    = head_q.inst;
   assign out_illegal = head_q.illegal;
   assign enc_count   = enc_count_q;

   assign push_s = in_valid & in_ready;
   assign pop_s  = out_valid & out_ready;

   // Head register is always the oldest word; a simultaneous push/pop only happens at count 1.
   always_comb begin
      count_d     = count_q;
      head_d      = head_q;
      tail_d      = tail_q;
      enc_count_d = enc_count_q;
      case ({push_s, pop_s})
         2'b10: begin
            if (count_q == 2'd0) begin
               head_d = packed_s;
            end else begin
               tail_d = packed_s;
            end
            count_d = count_q + 2'd1;
         end
         2'b01: begin
            if (count_q == 2'd2) begin
               head_d = tail_q;
            end else begin
               head_d = head_q;
            end
            count_d = count_q - 2'd1;
         end
         2'b11: head_d = packed_s;
         default: count_d = count_q;
      endcase
      if (pop_s && !head_q.illegal && (enc_count_q != {CNT_W{1'b1}})) begin
         enc_count_d = enc_count_q + CNT_W'(1);
      end else begin
         enc_count_d = enc_count_q;
      end
   end

   // State registers with asynchronous clear that also discards buffered words.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q     <= 2'd0;
         head_q      <= '0;
         tail_q      <= '0;
         enc_count_q <= '0;
      end else begin
         count_q     <= count_d;
         head_q      <= head_d;
         tail_q      <= tail_d;
         enc_count_q <= enc_count_d;
      end
   end

endmodule
